mem_access_unit: RTL

Load/store initiator that drives the word-wide, byte-addressed data memory of the multi-cycle CPU.
- Accepts one byte, halfword or word request at a time from the datapath and generates the memory's level read enable and edge-triggered write strobe with stable address and data.
- Performs lane extraction with sign/zero extension on loads.
- Performs read-modify-write for sub-word stores, because the memory writes only full 32-bit words.

---
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide, byte-addressed data memory: lane extract/extend on loads,
// read-modify-write on sub-word stores. Define MAU_ALIGN_CHECK_EN to reject misaligned accesses.
module mem_access_unit #(
  parameter int RD_WAIT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD, RCAP, WR_SETUP, WR_PULSE, WR_HOLD, RESP
  } state_t;

  localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  state_t            state, state_nxt;
  logic              req_we_p0, req_signed_p0;
  logic [1:0]        req_size_p0, req_lane_p0;
  logic [31:0]       req_wdata_p0;
  logic [CNT_W-1:0]  wait_cnt_p0, wait_cnt_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [31:0]       mem_wdata_nxt, resp_rdata_nxt;
  logic              resp_err_nxt;
  logic              accept, misaligned;

  // Shift the addressed lane down to bit 0 and extend; halfwords select by lane[1] only.
  function automatic logic [31:0] extend_lane(input logic [31:0] word, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] lane);
    logic [31:0]        sh_b, sh_h, res;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bx, hx;
    sh_b = word >> {lane, 3'b000};
    sh_h = word >> {lane[1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    bx   = b;
    hx   = h;
    case (size)
      2'b00:   res = sgn ? bx : {24'b0, sh_b[7:0]};
      2'b01:   res = sgn ? hx : {16'b0, sh_h[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] mask, ins;
    case (size)
      2'b00: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        ins  = {24'b0, wdata[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        ins  = {16'b0, wdata[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = wdata;
      end
    endcase
    return (old & ~mask) | ins;
  endfunction

  assign accept = (state == IDLE) && req_valid;

`ifdef MAU_ALIGN_CHECK_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt_p0;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    resp_rdata_nxt = resp_rdata;
    resp_err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          wait_cnt_nxt = CNT_W'(RD_WAIT - 1);
          if (misaligned) begin
            state_nxt      = RESP;
            resp_err_nxt   = 1'b1;
            resp_rdata_nxt = 32'h0;
          end else begin
            mem_addr_nxt = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_we && req_size[1]) begin
              mem_wdata_nxt = req_wdata;
              state_nxt     = WR_SETUP;
            end else begin
              state_nxt = RD;
            end
          end
        end
      end
      RD: begin
        if (wait_cnt_p0 == '0) state_nxt = RCAP;
        else wait_cnt_nxt = wait_cnt_p0 - CNT_W'(1);
      end
      RCAP: begin
        // mem_rdata is only valid here; it feeds either the merge or the load result directly.
        if (req_we_p0) begin
          mem_wdata_nxt = merge_lane(mem_rdata, req_wdata_p0, req_size_p0, req_lane_p0);
          state_nxt     = WR_SETUP;
        end else begin
          resp_rdata_nxt = extend_lane(mem_rdata, req_size_p0, req_signed_p0, req_lane_p0);
          state_nxt      = RESP;
        end
      end
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: state_nxt = WR_HOLD;
      WR_HOLD: begin
        resp_rdata_nxt = 32'h0;
        state_nxt      = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output registers: all outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
    end else begin
      state      <= state_nxt;
      req_ready  <= (state_nxt == IDLE);
      resp_valid <= (state_nxt == RESP);
      resp_err   <= resp_err_nxt;
      resp_rdata <= resp_rdata_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      mem_rd     <= (state_nxt == RD) || (state_nxt == RCAP);
      mem_wr     <= (state_nxt == WR_PULSE);
    end
  end

  // Request capture stage (_p0): fields held for the whole transaction.
  always_ff @(posedge clk) begin
    wait_cnt_p0 <= wait_cnt_nxt;
    if (accept) begin
      req_we_p0     <= req_we;
      req_signed_p0 <= req_signed;
      req_size_p0   <= req_size;
      req_lane_p0   <= req_addr[1:0];
      req_wdata_p0  <= req_wdata;
    end
  end

endmodule
